// File: rtl/dst_wb_if.sv
// rtl/dst_wb_if.sv - Wishbone master write bus between dst_wb_writer and memory
interface dst_wb_if;
    logic [31:0] wbm_adr_o;
    logic [63:0] wbm_dat_o;
    logic [7:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/dst_wb_writer.sv
// rtl/dst_wb_writer.sv - DMA destination FIFO drained to memory as Wishbone single writes
module dst_wb_writer #(
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        start,
    input  logic [31:0] dst_addr,
    input  logic        m_dst_putn,
    input  logic [63:0] m_dst,
    input  logic        m_dst_last,
    output logic        m_dst_full,
    output logic        m_dst_almost_full,
    dst_wb_if.master    wbm,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf,
    output logic [23:0] words_written
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   AF_LVL   = (DEPTH_LOG2+1)'(DEPTH - AFULL_MARGIN);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BUS, S_DONE} state_t;

    state_t state, state_d;

    logic [64:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  nonempty_q;

    logic [31:0] addr, addr_d;
    logic [31:0] adr_q, adr_d;
    logic [63:0] dat_q, dat_d;
    logic [7:0]  sel_q;
    logic        cyc_q, cyc_d;
    logic        busy_d, done_d, err_d;
    logic [23:0] ww_d;
    logic        pop, flush, clr;
    logic        push_ok, ovf_set;
    logic [63:0] head_data;
    logic        head_last;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^dst_addr[2:0];

    assign {head_last, head_data} = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok = !m_dst_putn && !flush && ((count != FULL_LVL) || pop);
    assign ovf_set = !m_dst_putn && (count == FULL_LVL) && !pop;

    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_we_o  = cyc_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;

    always_comb begin
        state_d = state;
        addr_d  = addr;
        adr_d   = adr_q;
        dat_d   = dat_q;
        cyc_d   = cyc_q;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = err;
        ww_d    = words_written;
        pop     = 1'b0;
        flush   = 1'b0;
        clr     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    busy_d  = 1'b1;
                    addr_d  = {dst_addr[31:3], 3'b000};
                    err_d   = 1'b0;
                    ww_d    = 24'd0;
                    clr     = 1'b1;
                end
            end
            S_WAIT: begin
                // Both the live count and the lagged flag must agree, so a word
                // popped on the previous edge is never re-issued.
                if ((count != '0) && nonempty_q) begin
                    state_d = S_BUS;
                    cyc_d   = 1'b1;
                    adr_d   = addr;
                    dat_d   = head_data;
                end
            end
            S_BUS: begin
                if (wbm.wbm_err_i) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (wbm.wbm_ack_i) begin
                    pop    = 1'b1;
                    cyc_d  = 1'b0;
                    addr_d = addr + 32'd8;
                    ww_d   = words_written + 24'd1;
                    if (head_last) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= {m_dst_last, m_dst};
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state             <= S_IDLE;
            addr              <= '0;
            adr_q             <= '0;
            dat_q             <= '0;
            sel_q             <= '0;
            cyc_q             <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            ovf               <= 1'b0;
            words_written     <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            nonempty_q        <= 1'b0;
            m_dst_full        <= 1'b0;
            m_dst_almost_full <= 1'b0;
        end else begin
            state         <= state_d;
            addr          <= addr_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            sel_q         <= 8'hFF;
            cyc_q         <= cyc_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
            words_written <= ww_d;

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr) begin
                ovf <= 1'b0;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (flush) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end

            // Flags follow the registered count one cycle late; the margin absorbs it.
            nonempty_q        <= (count != '0);
            m_dst_full        <= (count == FULL_LVL);
            m_dst_almost_full <= (count >= AF_LVL);
        end
    end
endmodule

// File: tb/tb_dst_wb_writer.sv
// tb/tb_dst_wb_writer.sv - directed self-checking bench for dst_wb_writer
module tb_dst_wb_writer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dst_addr = '0;
    logic        m_dst_putn = 1'b1;
    logic [63:0] m_dst = '0;
    logic        m_dst_last = 1'b0;
    logic        m_dst_full, m_dst_almost_full;
    logic        busy, done, err, ovf;
    logic [23:0] words_written;

    logic        slave_en = 1'b0;
    logic        force_ack = 1'b0;
    int          wait_states = 0;
    int          err_at = -1;
    logic        s_ack, s_err;
    int          wcnt;
    int          bus_idx = 0;
    int          log_n = 0;
    logic [31:0] log_adr [64];
    logic [63:0] log_dat [64];

    int tests = 0;
    int fails = 0;

    dst_wb_if wb ();

    assign wb.wbm_ack_i = slave_en ? s_ack : force_ack;
    assign wb.wbm_err_i = slave_en ? s_err : 1'b0;

    dst_wb_writer #(.DEPTH_LOG2(4), .AFULL_MARGIN(2)) dut (
        .wb_clk_i          (clk),
        .wb_rst_n          (rst_n),
        .start             (start),
        .dst_addr          (dst_addr),
        .m_dst_putn        (m_dst_putn),
        .m_dst             (m_dst),
        .m_dst_last        (m_dst_last),
        .m_dst_full        (m_dst_full),
        .m_dst_almost_full (m_dst_almost_full),
        .wbm               (wb),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .ovf               (ovf),
        .words_written     (words_written)
    );

    always #5 clk = ~clk;

    // Slave memory model: acks after wait_states cycles, errors on transaction err_at.
    initial begin
        s_ack = 1'b0;
        s_err = 1'b0;
        wcnt  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !slave_en) begin
                s_ack = 1'b0;
                s_err = 1'b0;
                wcnt  = 0;
            end else if (s_ack || s_err) begin
                s_ack = 1'b0;
                s_err = 1'b0;
            end else if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
                if (wcnt == wait_states) begin
                    wcnt = 0;
                    if (bus_idx == err_at) begin
                        s_err = 1'b1;
                    end else begin
                        s_ack = 1'b1;
                        if (log_n < 64) begin
                            log_adr[log_n] = wb.wbm_adr_o;
                            log_dat[log_n] = wb.wbm_dat_o;
                        end
                        log_n++;
                    end
                    bus_idx++;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] a);
        @(negedge clk);
        start    = 1'b1;
        dst_addr = a;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic push_words(input logic [63:0] base, input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_dst_putn = 1'b0;
            m_dst      = base + 64'(i);
            m_dst_last = (i == last_idx);
        end
        @(negedge clk);
        m_dst_putn = 1'b1;
        m_dst_last = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        tests++; if (wb.wbm_cyc_o !== 1'b0 || wb.wbm_stb_o !== 1'b0 || wb.wbm_we_o !== 1'b0) begin fails++; $display("FAIL reset_cyc_stb_we got %b%b%b want 000", wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o); end
        tests++; if (wb.wbm_adr_o !== 32'h0 || wb.wbm_dat_o !== 64'h0 || wb.wbm_sel_o !== 8'h0) begin fails++; $display("FAIL reset_bus got adr=%h dat=%h sel=%h want zeros", wb.wbm_adr_o, wb.wbm_dat_o, wb.wbm_sel_o); end
        tests++; if ({m_dst_full, m_dst_almost_full, busy, done, err, ovf} !== 6'b0) begin fails++; $display("FAIL reset_flags got %b want 000000", {m_dst_full, m_dst_almost_full, busy, done, err, ovf}); end
        tests++; if (words_written !== 24'd0) begin fails++; $display("FAIL reset_words got %0d want 0", words_written); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit seen;
        int base;
        slave_en = 1'b1; wait_states = 1; err_at = -1;
        base = log_n;
        do_start(32'h1000_0007);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
        push_words(64'hA5A5_0000_0000_0000, 4, 3);
        wait_done(200, seen);
        tests++; if (!seen) begin fails++; $display("FAIL basic_done got no pulse want pulse"); end
        tests++; if (busy !== 1'b0 || words_written !== 24'd4 || err !== 1'b0) begin fails++; $display("FAIL basic_status got busy=%b ww=%0d err=%b want 0 4 0", busy, words_written, err); end
        tests++; if (log_n - base !== 4) begin fails++; $display("FAIL basic_count got %0d want 4", log_n - base); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (log_adr[base+i] !== 32'h1000_0000 + 32'(8*i) || log_dat[base+i] !== 64'hA5A5_0000_0000_0000 + 64'(i)) begin
                fails++; $display("FAIL basic_write%0d got adr=%h dat=%h want adr=%h dat=%h", i, log_adr[base+i], log_dat[base+i], 32'h1000_0000 + 32'(8*i), 64'hA5A5_0000_0000_0000 + 64'(i));
            end
        end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width got %b want 0", done); end
    endtask

    task automatic test_latency;
        slave_en = 1'b1; wait_states = 0; err_at = -1;
        do_start(32'h4000_0000);
        repeat (3) @(negedge clk);
        m_dst_putn = 1'b0; m_dst = 64'h1234_5678_9ABC_DEF0; m_dst_last = 1'b1;
        @(negedge clk);
        m_dst_putn = 1'b1; m_dst_last = 1'b0;
        tests++; if (wb.wbm_stb_o !== 1'b0) begin fails++; $display("FAIL lat_n0 got stb=%b want 0", wb.wbm_stb_o); end
        @(negedge clk);
        tests++; if (wb.wbm_stb_o !== 1'b0) begin fails++; $display("FAIL lat_n1 got stb=%b want 0", wb.wbm_stb_o); end
        @(negedge clk);
        tests++; if (wb.wbm_stb_o !== 1'b1 || wb.wbm_cyc_o !== 1'b1 || wb.wbm_we_o !== 1'b1 || wb.wbm_sel_o !== 8'hFF) begin fails++; $display("FAIL lat_n2 got stb=%b cyc=%b we=%b sel=%h want 1 1 1 ff", wb.wbm_stb_o, wb.wbm_cyc_o, wb.wbm_we_o, wb.wbm_sel_o); end
        tests++; if (wb.wbm_adr_o !== 32'h4000_0000 || wb.wbm_dat_o !== 64'h1234_5678_9ABC_DEF0) begin fails++; $display("FAIL lat_bus got adr=%h dat=%h want 40000000 123456789abcdef0", wb.wbm_adr_o, wb.wbm_dat_o); end
        @(negedge clk);
        tests++; if (wb.wbm_stb_o !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || words_written !== 24'd1) begin fails++; $display("FAIL lat_end got stb=%b done=%b busy=%b ww=%0d want 0 1 0 1", wb.wbm_stb_o, done, busy, words_written); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit seen;
        int base;
        slave_en = 1'b0; err_at = -1;
        do_start(32'h2000_0000);
        push_words(64'hB000_0000_0000_0000, 13, -1);
        @(negedge clk);
        tests++; if (m_dst_almost_full !== 1'b0 || m_dst_full !== 1'b0) begin fails++; $display("FAIL bp_13 got af=%b full=%b want 0 0", m_dst_almost_full, m_dst_full); end
        push_words(64'hB000_0000_0000_000D, 1, -1);
        @(negedge clk);
        tests++; if (m_dst_almost_full !== 1'b1 || m_dst_full !== 1'b0) begin fails++; $display("FAIL bp_14 got af=%b full=%b want 1 0", m_dst_almost_full, m_dst_full); end
        push_words(64'hB000_0000_0000_000E, 1, -1);
        @(negedge clk);
        tests++; if (m_dst_full !== 1'b0) begin fails++; $display("FAIL bp_15 got full=%b want 0", m_dst_full); end
        push_words(64'hB000_0000_0000_000F, 1, 0);
        @(negedge clk);
        tests++; if (m_dst_full !== 1'b1 || ovf !== 1'b0) begin fails++; $display("FAIL bp_16 got full=%b ovf=%b want 1 0", m_dst_full, ovf); end
        push_words(64'hB000_0000_0000_0010, 1, -1);
        @(negedge clk);
        tests++; if (ovf !== 1'b1 || m_dst_full !== 1'b1) begin fails++; $display("FAIL bp_17 got ovf=%b full=%b want 1 1", ovf, m_dst_full); end
        base = log_n;
        wait_states = 0;
        slave_en = 1'b1;
        wait_done(400, seen);
        tests++; if (!seen || words_written !== 24'd16) begin fails++; $display("FAIL bp_drain got done=%b ww=%0d want 1 16", seen, words_written); end
        tests++; if (log_n - base !== 16) begin fails++; $display("FAIL bp_count got %0d want 16", log_n - base); end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (log_dat[base+i] !== 64'hB000_0000_0000_0000 + 64'(i) || log_adr[base+i] !== 32'h2000_0000 + 32'(8*i)) begin
                fails++; $display("FAIL bp_order%0d got adr=%h dat=%h want adr=%h dat=%h", i, log_adr[base+i], log_dat[base+i], 32'h2000_0000 + 32'(8*i), 64'hB000_0000_0000_0000 + 64'(i));
            end
        end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL bp_ovf_sticky got %b want 1", ovf); end
        @(negedge clk);
    endtask

    task automatic test_bus_error;
        bit seen;
        int base;
        slave_en = 1'b1; wait_states = 0; err_at = bus_idx + 1;
        base = log_n;
        do_start(32'h3000_0000);
        push_words(64'hC000_0000_0000_0000, 5, 4);
        wait_done(200, seen);
        tests++; if (!seen) begin fails++; $display("FAIL err_done got no pulse want pulse"); end
        tests++; if (err !== 1'b1 || words_written !== 24'd1 || busy !== 1'b0) begin fails++; $display("FAIL err_status got err=%b ww=%0d busy=%b want 1 1 0", err, words_written, busy); end
        tests++; if (log_n - base !== 1) begin fails++; $display("FAIL err_acked got %0d want 1", log_n - base); end
        repeat (4) @(negedge clk);
        err_at = -1;
        base = log_n;
        do_start(32'h3100_0000);
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", err); end
        push_words(64'hCAFE_0000_0000_0001, 1, 0);
        wait_done(200, seen);
        tests++; if (!seen || log_n - base !== 1 || log_dat[base] !== 64'hCAFE_0000_0000_0001 || log_adr[base] !== 32'h3100_0000) begin fails++; $display("FAIL err_flushed got done=%b n=%0d adr=%h dat=%h want 1 1 31000000 cafe000000000001", seen, log_n - base, log_adr[base], log_dat[base]); end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        bit seen;
        int base;
        slave_en = 1'b1; wait_states = 0; err_at = -1;
        base = log_n;
        do_start(32'hFFFF_FFF8);
        push_words(64'hD000_0000_0000_0000, 2, 1);
        wait_done(200, seen);
        tests++; if (!seen || log_n - base !== 2) begin fails++; $display("FAIL wrap_count got done=%b n=%0d want 1 2", seen, log_n - base); end
        tests++; if (log_adr[base] !== 32'hFFFF_FFF8 || log_adr[base+1] !== 32'h0000_0000) begin fails++; $display("FAIL wrap_addr got %h %h want fffffff8 00000000", log_adr[base], log_adr[base+1]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bus;
        bit seen;
        bit hit;
        int base;
        slave_en = 1'b0; err_at = -1;
        do_start(32'h6000_0000);
        push_words(64'hE000_0000_0000_0000, 1, 0);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wb.wbm_stb_o) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        tests++; if (!hit) begin fails++; $display("FAIL rst_setup got stb=0 want 1"); end
        rst_n = 1'b0;
        #1;
        tests++; if (wb.wbm_cyc_o !== 1'b0 || wb.wbm_stb_o !== 1'b0 || wb.wbm_we_o !== 1'b0 || wb.wbm_adr_o !== 32'h0 || wb.wbm_sel_o !== 8'h0) begin fails++; $display("FAIL rst_bus got cyc=%b stb=%b we=%b adr=%h sel=%h want zeros", wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_sel_o); end
        tests++; if ({busy, done, err, ovf, m_dst_full, m_dst_almost_full} !== 6'b0 || words_written !== 24'd0) begin fails++; $display("FAIL rst_state got flags=%b ww=%0d want 000000 0", {busy, done, err, ovf, m_dst_full, m_dst_almost_full}, words_written); end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL rst_no_done got done pulse want none"); end
        slave_en = 1'b1; wait_states = 0;
        base = log_n;
        do_start(32'h6100_0000);
        push_words(64'hE100_0000_0000_0000, 2, 1);
        wait_done(200, seen);
        tests++; if (!seen || words_written !== 24'd2 || log_n - base !== 2) begin fails++; $display("FAIL rst_rejob got done=%b ww=%0d n=%0d want 1 2 2", seen, words_written, log_n - base); end
        tests++; if (log_dat[base] !== 64'hE100_0000_0000_0000 || log_dat[base+1] !== 64'hE100_0000_0000_0001 || log_adr[base+1] !== 32'h6100_0008) begin fails++; $display("FAIL rst_rejob_data got %h %h adr=%h want e100000000000000 e100000000000001 61000008", log_dat[base], log_dat[base+1], log_adr[base+1]); end
        @(negedge clk);
    endtask

    task automatic test_push_pop_full;
        bit seen;
        int base;
        slave_en = 1'b0; force_ack = 1'b0; err_at = -1;
        do_start(32'h5000_0000);
        push_words(64'hF000_0000_0000_0000, 16, -1);
        @(negedge clk);
        tests++; if (m_dst_full !== 1'b1 || wb.wbm_stb_o !== 1'b1) begin fails++; $display("FAIL pp_full got full=%b stb=%b want 1 1", m_dst_full, wb.wbm_stb_o); end
        force_ack  = 1'b1;
        m_dst_putn = 1'b0; m_dst = 64'hDEAD_BEEF_0000_0011; m_dst_last = 1'b1;
        @(negedge clk);
        force_ack  = 1'b0;
        m_dst_putn = 1'b1; m_dst_last = 1'b0;
        tests++; if (ovf !== 1'b0 || m_dst_full !== 1'b1) begin fails++; $display("FAIL pp_edge got ovf=%b full=%b want 0 1", ovf, m_dst_full); end
        @(negedge clk);
        tests++; if (m_dst_full !== 1'b1) begin fails++; $display("FAIL pp_hold got full=%b want 1", m_dst_full); end
        base = log_n;
        wait_states = 0;
        slave_en = 1'b1;
        wait_done(400, seen);
        tests++; if (!seen || words_written !== 24'd17 || log_n - base !== 16 || ovf !== 1'b0) begin fails++; $display("FAIL pp_drain got done=%b ww=%0d n=%0d ovf=%b want 1 17 16 0", seen, words_written, log_n - base, ovf); end
        for (int i = 0; i < 15; i++) begin
            tests++;
            if (log_dat[base+i] !== 64'hF000_0000_0000_0001 + 64'(i)) begin
                fails++; $display("FAIL pp_order%0d got %h want %h", i, log_dat[base+i], 64'hF000_0000_0000_0001 + 64'(i));
            end
        end
        tests++; if (log_dat[base+15] !== 64'hDEAD_BEEF_0000_0011 || log_adr[base+15] !== 32'h5000_0080) begin fails++; $display("FAIL pp_tail got adr=%h dat=%h want 50000080 deadbeef00000011", log_adr[base+15], log_dat[base+15]); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_bus_error();
        test_wrap();
        test_reset_mid_bus();
        test_push_pop_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
